data_perm_blk_multi: RTL and testbench

- Parametrised multi-lane frame reorder buffer for the streaming FFT datapath. Successor to the single-lane skewed-read FIFO block.
- Each lane writes a FRAME_LEN-word frame in arrival order, then reads it back in one of two orders:
  - skewed natural order, with a per-lane rotation;
  - skewed bit-reversed order.
- Ping-pong banks allow back-to-back frames at full throughput. Sits between FFT butterfly stages and at the FFT output.

---
 rtl/data_perm_blk_multi.sv | 212 +++++++++++++++++++++
 tb/tb_data_perm_blk_multi.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_perm_blk_multi.sv
// Multi-lane ping-pong frame reorder buffer: per-lane skewed natural or bit-reversed readout.
// Latency: first output word 2 cycles after the last word of a frame is written.
// No backpressure: input accepted every cycle, output streams at full rate once a bank is full.
module data_perm_blk_multi #(
    parameter int DATA_W    = 32,
    parameter int LANES     = 4,
    parameter int FRAME_LEN = 16,
    parameter int AW        = 4,
    parameter int RD_SKEW   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DATA_W-1:0] data_in,
    input  logic                    ctrl_in,
    input  logic                    rd_mode,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic                    ctrl_out,
    output logic                    valid_out,
    output logic [LANES*AW-1:0]     addr,
    output logic                    frame_err
);

    typedef enum logic {R_IDLE, R_RUN} rd_state_t;

    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) r[b] = a[AW-1-b];
        return r;
    endfunction

    function automatic logic [AW-1:0] lane_skew(input int l);
        return AW'((l * RD_SKEW) % FRAME_LEN);
    endfunction

    logic [DATA_W-1:0] mem [2][LANES][FRAME_LEN];

    // write side
    logic              wact_q, wact_d;
    logic [AW-1:0]     wc_q, wc_d;
    logic              wb_q, wb_d;
    logic              wmode_q, wmode_d;
    logic [1:0]        full_q, full_d;
    logic [1:0]        mode_q, mode_d;
    logic              ferr_q, ferr_d;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic              fr_done;

    // read side
    rd_state_t         state_q, state_d;
    logic [AW-1:0]     rc_q, rc_d;
    logic              rb_q, rb_d;
    logic              rd_fire, rd_done;
    logic [LANES*AW-1:0]     ra;
    logic [LANES*DATA_W-1:0] rd_dat_q, rd_dat_d;

    // output pipeline
    logic                    v1_q, v1_d, c1_q, c1_d;
    logic [LANES*AW-1:0]     ra1_q, ra1_d;
    logic [LANES*DATA_W-1:0] dout_q, dout_d;
    logic                    vout_q, vout_d, cout_q, cout_d;
    logic [LANES*AW-1:0]     addr_q, addr_d;

    always_comb begin
        wact_d  = wact_q;
        wc_d    = wc_q;
        wb_d    = wb_q;
        wmode_d = wmode_q;
        ferr_d  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = wc_q;
        fr_done = 1'b0;
        if (ctrl_in) begin
            // a start while a frame is open abandons it and reuses the same bank
            ferr_d  = wact_q;
            wr_en   = 1'b1;
            wr_addr = '0;
            wc_d    = AW'(1);
            wact_d  = 1'b1;
            wmode_d = rd_mode;
        end else if (wact_q) begin
            wr_en = 1'b1;
            if (wc_q == LAST) begin
                fr_done = 1'b1;
                wact_d  = 1'b0;
                wc_d    = '0;
                wb_d    = ~wb_q;
            end else begin
                wc_d = wc_q + AW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        rb_d    = rb_q;
        rd_fire = 1'b0;
        rd_done = 1'b0;
        case (state_q)
            R_IDLE:  rd_fire = full_q[rb_q];
            R_RUN:   rd_fire = 1'b1;
            default: rd_fire = 1'b0;
        endcase
        if (rd_fire) begin
            if (rc_q == LAST) begin
                rd_done = 1'b1;
                rc_d    = '0;
                rb_d    = ~rb_q;
                state_d = full_q[~rb_q] ? R_RUN : R_IDLE;
            end else begin
                rc_d    = rc_q + AW'(1);
                state_d = R_RUN;
            end
        end
    end

    // a bank freed by the reader and one filled by the writer are never the same bank
    always_comb begin
        full_d = full_q;
        mode_d = mode_q;
        if (rd_done) full_d[rb_q] = 1'b0;
        if (fr_done) begin
            full_d[wb_q] = 1'b1;
            mode_d[wb_q] = wmode_q;
        end
    end

    always_comb begin
        ra       = '0;
        rd_dat_d = rd_dat_q;
        for (int l = 0; l < LANES; l++) begin
            ra[l*AW +: AW] = mode_q[rb_q] ? bitrev(rc_q + lane_skew(l)) : (rc_q + lane_skew(l));
        end
        if (rd_fire) begin
            for (int l = 0; l < LANES; l++) begin
                rd_dat_d[l*DATA_W +: DATA_W] = mem[rb_q][l][ra[l*AW +: AW]];
            end
        end
    end

    always_comb begin
        v1_d   = rd_fire;
        c1_d   = rd_fire && (rc_q == '0);
        ra1_d  = rd_fire ? ra : ra1_q;
        vout_d = v1_q;
        cout_d = c1_q;
        dout_d = v1_q ? rd_dat_q : dout_q;
        addr_d = v1_q ? ra1_q : addr_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                mem[wb_q][l][wr_addr] <= data_in[l*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wact_q   <= 1'b0;
            wc_q     <= '0;
            wb_q     <= 1'b0;
            wmode_q  <= 1'b0;
            full_q   <= '0;
            mode_q   <= '0;
            ferr_q   <= 1'b0;
            state_q  <= R_IDLE;
            rc_q     <= '0;
            rb_q     <= 1'b0;
            rd_dat_q <= '0;
            v1_q     <= 1'b0;
            c1_q     <= 1'b0;
            ra1_q    <= '0;
            dout_q   <= '0;
            vout_q   <= 1'b0;
            cout_q   <= 1'b0;
            addr_q   <= '0;
        end else begin
            wact_q   <= wact_d;
            wc_q     <= wc_d;
            wb_q     <= wb_d;
            wmode_q  <= wmode_d;
            full_q   <= full_d;
            mode_q   <= mode_d;
            ferr_q   <= ferr_d;
            state_q  <= state_d;
            rc_q     <= rc_d;
            rb_q     <= rb_d;
            rd_dat_q <= rd_dat_d;
            v1_q     <= v1_d;
            c1_q     <= c1_d;
            ra1_q    <= ra1_d;
            dout_q   <= dout_d;
            vout_q   <= vout_d;
            cout_q   <= cout_d;
            addr_q   <= addr_d;
        end
    end

    bank_owner_a: assert property (@(posedge clk) disable iff (!rst) wr_en |-> !full_q[wb_q]);

    assign data_out  = dout_q;
    assign valid_out = vout_q;
    assign ctrl_out  = cout_q;
    assign addr      = addr_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_data_perm_blk_multi.sv
// Bench for data_perm_blk_multi: directed frames plus random traffic against a frame-level model.
module tb_data_perm_blk_multi;

    localparam int DW  = 32;
    localparam int L   = 4;
    localparam int FL  = 16;
    localparam int AWL = 4;
    localparam int SK  = 4;

    typedef struct {
        int               cyc;
        logic [L*DW-1:0]  dat;
        logic [L*AWL-1:0] adr;
        bit               first;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [L*DW-1:0]   data_in;
    logic              ctrl_in;
    logic              rd_mode;
    logic [L*DW-1:0]   data_out;
    logic              ctrl_out;
    logic              valid_out;
    logic [L*AWL-1:0]  addr;
    logic              frame_err;

    data_perm_blk_multi #(.DATA_W(DW), .LANES(L), .FRAME_LEN(FL), .AW(AWL), .RD_SKEW(SK)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .ctrl_in(ctrl_in), .rd_mode(rd_mode),
        .data_out(data_out), .ctrl_out(ctrl_out), .valid_out(valid_out), .addr(addr),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    exp_t             exp_q[$];
    logic [DW-1:0]    fbuf [FL][L];
    bit               m_wact;
    int               m_wc;
    bit               m_mode;
    int               next_free;
    bit               err_exp;
    logic [L*DW-1:0]  last_dat;
    logic [L*AWL-1:0] last_adr;

    // observation captures
    int            out_k, seen_k, first_cyc;
    int            cnt_valid, cnt_ctrl, cnt_ferr;
    logic [DW-1:0] cap_l0 [FL];
    logic [DW-1:0] cap_l1 [FL];
    logic [DW-1:0] cap_l3 [FL];
    logic [AWL-1:0] cap_a1 [FL];

    task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int brev(input int a);
        int r = 0;
        for (int b = 0; b < AWL; b++) r = r * 2 + ((a >> b) & 1);
        return r;
    endfunction

    function automatic logic [L*DW-1:0] pat(input int i);
        logic [L*DW-1:0] v;
        for (int l = 0; l < L; l++) v[l*DW +: DW] = DW'(4 * i + l + 1);
        return v;
    endfunction

    function automatic logic [L*DW-1:0] rnd_vec();
        logic [L*DW-1:0] v;
        for (int l = 0; l < L; l++) v[l*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_wact    = 1'b0;
        m_wc      = 0;
        next_free = 0;
        err_exp   = 1'b0;
        last_dat  = '0;
        last_adr  = '0;
    endtask

    // a completed frame streams out 2 cycles later, or right after the previous frame
    task automatic model_complete();
        exp_t e;
        int   start, a;
        start = (cyc + 2 > next_free) ? cyc + 2 : next_free;
        for (int k = 0; k < FL; k++) begin
            e.cyc   = start + k;
            e.first = (k == 0);
            for (int l = 0; l < L; l++) begin
                a = (k + l * SK) % FL;
                if (m_mode) a = brev(a);
                e.dat[l*DW +: DW]   = fbuf[a][l];
                e.adr[l*AWL +: AWL] = a[AWL-1:0];
            end
            exp_q.push_back(e);
        end
        next_free = start + FL;
    endtask

    task automatic model_edge(input logic c, input logic m, input logic [L*DW-1:0] d);
        err_exp = 1'b0;
        if (!rst) begin
            model_reset();
        end else if (c) begin
            err_exp = m_wact;
            for (int l = 0; l < L; l++) fbuf[0][l] = d[l*DW +: DW];
            m_wc   = 1;
            m_wact = 1'b1;
            m_mode = m;
        end else if (m_wact) begin
            for (int l = 0; l < L; l++) fbuf[m_wc][l] = d[l*DW +: DW];
            if (m_wc == FL - 1) begin
                model_complete();
                m_wact = 1'b0;
            end else begin
                m_wc++;
            end
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        seen_k = -1;
        if (valid_out === 1'b1) cnt_valid++;
        if (ctrl_out === 1'b1) cnt_ctrl++;
        if (frame_err === 1'b1) cnt_ferr++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk_eq("valid", valid_out, 1);
            chk_eq("ctrl", ctrl_out, e.first);
            chk_eq("data", data_out, e.dat);
            chk_eq("addr", addr, e.adr);
            last_dat = e.dat;
            last_adr = e.adr;
            if (e.first) begin
                out_k     = 0;
                first_cyc = cyc;
            end else begin
                out_k++;
            end
            seen_k = out_k;
            if (out_k < FL) begin
                cap_l0[out_k] = data_out[0*DW +: DW];
                cap_l1[out_k] = data_out[1*DW +: DW];
                cap_l3[out_k] = data_out[3*DW +: DW];
                cap_a1[out_k] = addr[1*AWL +: AWL];
            end
        end else begin
            chk_eq("valid_idle", valid_out, 0);
            chk_eq("ctrl_idle", ctrl_out, 0);
            chk_eq("data_hold", data_out, last_dat);
            chk_eq("addr_hold", addr, last_adr);
        end
        chk_eq("frame_err", frame_err, err_exp);
    endtask

    task automatic step(input logic c, input logic m, input logic [L*DW-1:0] d);
        ctrl_in = c;
        rd_mode = m;
        data_in = d;
        @(posedge clk);
        cyc++;
        model_edge(c, m, d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_pat_frame(input logic m);
        for (int i = 0; i < FL; i++) step(i == 0, m, pat(i));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), rnd_vec());
    endtask

    task automatic check_natural_frame(input string tag, input int e0);
        chk_eq({tag, "_start"}, first_cyc, e0 + 17);
        chk_eq({tag, "_l0_w0"}, cap_l0[0], 1);
        chk_eq({tag, "_l0_w1"}, cap_l0[1], 5);
        chk_eq({tag, "_l0_w15"}, cap_l0[15], 61);
        chk_eq({tag, "_l1_w0"}, cap_l1[0], 18);
        chk_eq({tag, "_l1_w11"}, cap_l1[11], 62);
        chk_eq({tag, "_l1_wrap"}, cap_l1[12], 2);
        chk_eq({tag, "_l3_w0"}, cap_l3[0], 52);
    endtask

    initial begin
        int e0, r, ab, gap;
        logic m;
        ctrl_in = 1'b0;
        rd_mode = 1'b0;
        data_in = '0;
        rst     = 1'b1;
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk_eq("rst_data", data_out, 0);
        chk_eq("rst_valid", valid_out, 0);
        chk_eq("rst_ctrl", ctrl_out, 0);
        chk_eq("rst_addr", addr, 0);
        chk_eq("rst_ferr", frame_err, 0);

        // reset held while ctrl_in toggles
        cnt_valid = 0; cnt_ctrl = 0;
        for (int i = 0; i < 10; i++) step(1'(i % 2), 1'b0, pat(i));
        chk_eq("s1_no_valid", cnt_valid, 0);
        chk_eq("s1_no_ctrl", cnt_ctrl, 0);
        rst = 1'b1;
        idle(3);

        // single natural frame
        cnt_valid = 0; cnt_ctrl = 0;
        e0 = cyc + 1;
        send_pat_frame(1'b0);
        idle(20);
        chk_eq("s2_valid_cycles", cnt_valid, 16);
        chk_eq("s2_ctrl_pulses", cnt_ctrl, 1);
        check_natural_frame("s2", e0);

        // four back-to-back frames
        cnt_valid = 0; cnt_ctrl = 0;
        e0 = cyc + 1;
        for (int f = 0; f < 4; f++) send_pat_frame(1'b0);
        idle(20);
        chk_eq("s3_valid_cycles", cnt_valid, 64);
        chk_eq("s3_ctrl_pulses", cnt_ctrl, 4);
        check_natural_frame("s3_last", e0 + 48);

        // bit-reversed frame
        send_pat_frame(1'b1);
        idle(20);
        chk_eq("s4_l0_w0", cap_l0[0], 1);
        chk_eq("s4_l0_w1", cap_l0[1], 33);
        chk_eq("s4_l0_w2", cap_l0[2], 17);
        chk_eq("s4_l0_w3", cap_l0[3], 49);
        chk_eq("s4_l0_w4", cap_l0[4], 9);
        chk_eq("s4_a1_w0", cap_a1[0], 2);
        chk_eq("s4_a1_w1", cap_a1[1], 10);
        chk_eq("s4_a1_w2", cap_a1[2], 6);
        chk_eq("s4_a1_w3", cap_a1[3], 14);

        // restart at wc=7
        cnt_valid = 0; cnt_ferr = 0; cnt_ctrl = 0;
        for (int i = 0; i < 7; i++) step(i == 0, 1'b0, pat(i + 100));
        r = cyc + 1;
        send_pat_frame(1'b0);
        idle(20);
        chk_eq("s5_ferr_pulses", cnt_ferr, 1);
        chk_eq("s5_valid_cycles", cnt_valid, 16);
        chk_eq("s5_ctrl_pulses", cnt_ctrl, 1);
        check_natural_frame("s5", r);

        // reset while output word 5 is on the bus
        send_pat_frame(1'b0);
        for (int t = 0; t < 40; t++) begin
            step(1'b0, 1'b0, rnd_vec());
            if (seen_k == 5) break;
        end
        chk_eq("s6_reach_w5", seen_k, 5);
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk_eq("s6_rst_data", data_out, 0);
        chk_eq("s6_rst_valid", valid_out, 0);
        chk_eq("s6_rst_addr", addr, 0);
        idle(3);
        rst = 1'b1;
        cnt_valid = 0;
        idle(30);
        chk_eq("s6_quiet", cnt_valid, 0);
        cnt_ctrl = 0;
        e0 = cyc + 1;
        send_pat_frame(1'b0);
        idle(20);
        chk_eq("s6_ctrl_pulses", cnt_ctrl, 1);
        check_natural_frame("s6", e0);

        // random traffic: random data, modes, gaps and aborts
        for (int f = 0; f < 30; f++) begin
            m = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                ab = $urandom_range(1, FL - 1);
                for (int i = 0; i < ab; i++) step(i == 0, i == 0 ? m : 1'($urandom_range(0, 1)), rnd_vec());
            end
            for (int i = 0; i < FL; i++) step(i == 0, i == 0 ? m : 1'($urandom_range(0, 1)), rnd_vec());
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(gap);
        end
        idle(40);
        chk_eq("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
